updown_mod_counter: RTL and testbench
=====================================

// Module: updown_mod_counter
// PURPOSE
//  Parametrised up/down modulo counter; next generation of the team's loadable counter.
//  Adds direction control, a programmable terminal value, wrap or saturate mode, and registered
//  terminal-count and wrap flags. Used as a general timing/event counter inside lab datapaths.
// PARAMETERS
//  WIDTH     5             counter width in bits (>=2)
//  MAX_VAL   2**WIDTH-1    terminal (top) count; legal range 1..2**WIDTH-1
//  SATURATE  0             0 = wrap at the boundary, 1 = hold at the boundary
//  PRESCALE  4             enab qualifier divide ratio (>=2); used only when CNT_PRESCALE_EN is defined
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      synchronous reset, active-high
//  load     in   1      load cnt_in on the next edge
//  enab     in   1      count enable
//  up_dn    in   1      1 = count up, 0 = count down
//  cnt_in   in   WIDTH  load value
//  cnt_out  out  WIDTH  registered count
//  at_max   out  1      registered; 1 when cnt_out == MAX_VAL
//  at_min   out  1      registered; 1 when cnt_out == 0
//  wrap     out  1      registered one-cycle pulse: the count wrapped on the last edge
//  sat      out  1      registered; 1 while a step was blocked at a boundary (SATURATE=1 only)
// BEHAVIOUR
//  - All outputs change only on posedge clk. Priority: rst > load > enab > hold.
//  - rst: cnt_out=0, at_min=1, at_max=0, wrap=0, sat=0, prescaler=0.
//  - load: cnt_out = (cnt_in > MAX_VAL) ? MAX_VAL : cnt_in. Out-of-range loads are clamped.
//    Load clears wrap/sat, resets the prescaler, and takes effect in 1 cycle.
//  - Step (enab=1 and prescale tick): up: cnt+1. Down: cnt-1.
//    Up at MAX_VAL: wrap to 0 with wrap=1 (SATURATE=0), or hold MAX_VAL with sat=1 (SATURATE=1).
//    Down at 0: wrap to MAX_VAL with wrap=1, or hold 0 with sat=1.
//  - wrap is high for exactly the one cycle following the wrapping edge. sat is high for each
//    cycle following a blocked step, and clears on the next non-blocked edge.
//  - at_max/at_min are computed from the next-state value and registered with cnt_out,
//    so they are never a cycle stale. When cnt_out==MAX_VAL==0 is impossible (MAX_VAL>=1).
//  - Arithmetic is done in WIDTH+1 bits internally; no silent binary roll-over.
//    Wrap happens only at MAX_VAL/0.
//  - up_dn may change on any cycle; the value sampled at the edge governs that step.
//  - enab=0: cnt_out holds, wrap=0, sat=0, flags consistent with held value.
//  - rst asserted mid-count overrides load/enab in that same edge.
// CONFIGURATION
//  CNT_PRESCALE_EN defined: an internal modulo-PRESCALE counter advances on each enab=1 cycle.
//    The main counter steps only on the enab cycle where the prescaler is at PRESCALE-1, then the
//    prescaler returns to 0. The prescaler holds when enab=0 and is cleared by rst and load.
//  CNT_PRESCALE_EN undefined: every enab=1 cycle is a step. PRESCALE is ignored and no prescaler
//    logic is built.
// TESTING  (WIDTH=4, MAX_VAL=9 unless noted)
//  1 rst=1 one cycle, then enab=1 up_dn=1 for 12 cycles -> cnt 1..9,0,1,2; wrap=1 only in the cycle
//    cnt shows 0; at_max=1 when cnt=9.
//  2 load=1 cnt_in=4, then enab=1 up_dn=0 for 6 cycles -> 4,3,2,1,0,9,8; wrap pulses with cnt=9;
//    at_min=1 with cnt=0.
//  3 SATURATE=1: load 8, enab up 3 cycles -> 9,9,9; sat=1 on the 2nd and 3rd; then up_dn=0 -> 8,
//    sat=0.
//  4 load cnt_in=15 -> cnt_out=9, at_max=1. load+enab+rst together -> cnt_out=0 next edge.
//  5 CNT_PRESCALE_EN, PRESCALE=4: enab=1 for 8 cycles from 0 -> cnt steps on cycles 4 and 8 only
//    (final 2). With enab gaps, the prescaler holds and the step count matches enab pulses/4.

Source files
------------

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo counter with programmable top, wrap or saturate, registered flags.
// Build macro CNT_PRESCALE_EN adds an enab prescaler so the counter steps once every PRESCALE enab cycles.
module updown_mod_counter #(
  parameter int WIDTH    = 5,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   ONE_X  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   ZERO_X = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH-1:0] MAX_W  = MAX_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  // An illegal parameter set freezes stepping instead of counting through an undefined range.
  localparam logic CFG_OK = (WIDTH >= 2) && (MAX_VAL >= 1) && (MAX_VAL <= 2**WIDTH-1)
                            && (PRESCALE >= 2);

  logic             step_s;
  logic [WIDTH:0]   cnt_x_s;
  logic [WIDTH:0]   arith_x_s;
  logic [WIDTH-1:0] nxt_cnt_s;
  logic             nxt_wrap_s;
  logic             nxt_sat_s;

  logic [WIDTH-1:0] cnt_r;
  logic             at_max_r;
  logic             at_min_r;
  logic             wrap_r;
  logic             sat_r;

`ifdef CNT_PRESCALE_EN
  localparam int            PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_TOP = PW'(PRESCALE-1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);

  logic [PW-1:0] pre_r;

  assign step_s = enab && (pre_r == PRE_TOP) && CFG_OK;

  // Prescaler: advances on enab, returns to zero on the stepping cycle, cleared by rst and load.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      pre_r <= {PW{1'b0}};
    end else if (enab) begin
      if (pre_r == PRE_TOP) pre_r <= {PW{1'b0}};
      else                  pre_r <= pre_r + PRE_ONE;
    end else begin
      pre_r <= pre_r;
    end
  end
`else
  assign step_s = enab && CFG_OK;
`endif

  // Next-state: load clamp, then a boundary-aware step in WIDTH+1 bits, else hold.
  always_comb begin
    cnt_x_s    = {1'b0, cnt_r};
    arith_x_s  = ZERO_X;
    nxt_cnt_s  = cnt_r;
    nxt_wrap_s = 1'b0;
    nxt_sat_s  = 1'b0;
    if (load) begin
      if ({1'b0, cnt_in} > MAX_X) nxt_cnt_s = MAX_W;
      else                        nxt_cnt_s = cnt_in;
    end else if (step_s) begin
      if (up_dn) begin
        if (cnt_x_s >= MAX_X) begin
          if (SATURATE != 0) begin
            nxt_cnt_s = MAX_W;
            nxt_sat_s = 1'b1;
          end else begin
            nxt_cnt_s  = ZERO_W;
            nxt_wrap_s = 1'b1;
          end
        end else begin
          arith_x_s = cnt_x_s + ONE_X;
          nxt_cnt_s = arith_x_s[WIDTH-1:0];
        end
      end else begin
        if (cnt_x_s == ZERO_X) begin
          if (SATURATE != 0) begin
            nxt_cnt_s = ZERO_W;
            nxt_sat_s = 1'b1;
          end else begin
            nxt_cnt_s  = MAX_W;
            nxt_wrap_s = 1'b1;
          end
        end else begin
          arith_x_s = cnt_x_s - ONE_X;
          nxt_cnt_s = arith_x_s[WIDTH-1:0];
        end
      end
    end else begin
      nxt_cnt_s = cnt_r;
    end
  end

  // State register: flags are derived from the next count so they never lag cnt_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= ZERO_W;
      at_max_r <= 1'b0;
      at_min_r <= 1'b1;
      wrap_r   <= 1'b0;
      sat_r    <= 1'b0;
    end else begin
      cnt_r    <= nxt_cnt_s;
      at_max_r <= (nxt_cnt_s == MAX_W);
      at_min_r <= (nxt_cnt_s == ZERO_W);
      wrap_r   <= nxt_wrap_s;
      sat_r    <= nxt_sat_s;
    end
  end

  assign cnt_out = cnt_r;
  assign at_max  = at_max_r;
  assign at_min  = at_min_r;
  assign wrap    = wrap_r;
  assign sat     = sat_r;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter (WIDTH=4, MAX_VAL=9), wrap and saturate instances side by side.
// Honours CNT_PRESCALE_EN in its reference model when the build defines it.
module tb_updown_mod_counter;

  localparam int WIDTH = 4;
  localparam int MAXV  = 9;
  localparam int PRE   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0, load = 1'b0, enab = 1'b0, up_dn = 1'b0;
  logic [WIDTH-1:0] cnt_in = 4'd0;

  logic [WIDTH-1:0] cnt_w, cnt_s;
  logic at_max_w, at_min_w, wrap_w, sat_w;
  logic at_max_s, at_min_s, wrap_s, sat_s;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_w[$];
  logic [7:0] q_s[$];
  logic [7:0] exp_w, exp_s;

  int m_cnt_w = 0;
  int m_cnt_s = 0;
  int m_pre   = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(WIDTH), .MAX_VAL(MAXV), .SATURATE(0), .PRESCALE(PRE)) dut_w (
    .clk(clk), .rst(rst), .load(load), .enab(enab), .up_dn(up_dn), .cnt_in(cnt_in),
    .cnt_out(cnt_w), .at_max(at_max_w), .at_min(at_min_w), .wrap(wrap_w), .sat(sat_w));

  updown_mod_counter #(.WIDTH(WIDTH), .MAX_VAL(MAXV), .SATURATE(1), .PRESCALE(PRE)) dut_s (
    .clk(clk), .rst(rst), .load(load), .enab(enab), .up_dn(up_dn), .cnt_in(cnt_in),
    .cnt_out(cnt_s), .at_max(at_max_s), .at_min(at_min_s), .wrap(wrap_s), .sat(sat_s));

  // Reference: counting is modular arithmetic over 0..MAXV unless saturating at an edge.
  task automatic model(input logic r, input logic l, input logic e, input logic u,
                       input logic [3:0] ci, input bit tick, input bit satm,
                       inout int c, output logic [7:0] ex);
    bit w = 1'b0;
    bit s = 1'b0;
    bit at_edge;
    if (r) begin
      c = 0;
    end else if (l) begin
      c = (int'(ci) > MAXV) ? MAXV : int'(ci);
    end else if (e && tick) begin
      at_edge = u ? (c == MAXV) : (c == 0);
      if (at_edge && satm) begin
        s = 1'b1;
      end else begin
        w = at_edge;
        c = (c + (u ? 1 : MAXV)) % (MAXV + 1);
      end
    end
    ex = {4'(c), (c == MAXV), (c == 0), w, s};
  endtask

  task automatic drive(input logic r, input logic l, input logic e, input logic u,
                       input logic [3:0] ci);
    logic [7:0] ew, es;
    bit tick;
    @(negedge clk);
    rst = r; load = l; enab = e; up_dn = u; cnt_in = ci;
`ifdef CNT_PRESCALE_EN
    tick = (m_pre == PRE - 1);
    if (r || l)   m_pre = 0;
    else if (e)   m_pre = (m_pre + 1) % PRE;
`else
    tick = 1'b1;
`endif
    model(r, l, e, u, ci, tick, 1'b0, m_cnt_w, ew);
    model(r, l, e, u, ci, tick, 1'b1, m_cnt_s, es);
    q_w.push_back(ew);
    q_s.push_back(es);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t {cnt,max,min,wrap,sat} got=%b_%b expected=%b_%b",
               name, $time, got[7:4], got[3:0], exp[7:4], exp[3:0]);
    end
  endtask

  // Monitor: the DUT presents a fresh result every edge; compare it against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (q_w.size() > 0) begin
      exp_w = q_w.pop_front();
      check("wrap_dut", {cnt_w, at_max_w, at_min_w, wrap_w, sat_w}, exp_w);
    end
    if (q_s.size() > 0) begin
      exp_s = q_s.pop_front();
      check("sat_dut", {cnt_s, at_max_s, at_min_s, wrap_s, sat_s}, exp_s);
    end
  end

  initial begin
    // Reset, then count up through the wrap.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    // Load 4 and count down through zero.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    // Load 8, push against the top, then step back down.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd8);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    // Hold with enab low.
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    // Out-of-range load clamps, then rst beats load and enab.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd15);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    // Long enab run from zero, then gapped enab.
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 24; i++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 4'd0);
    // Saturate at zero on the way down.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
    end
    @(negedge clk);
    rst = 1'b0; load = 1'b0; enab = 1'b0;
    for (int i = 0; i < 5 && (q_w.size() > 0 || q_s.size() > 0); i++) @(posedge clk);
    #2;
    if (q_w.size() > 0 || q_s.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q_w.size() + q_s.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
